// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX FIFO between N_REQ byte sources, plus config-request sequencing.
// 1-cycle arbitration; granted bytes pass combinationally, ready drops on FIFO full. Option macro: UART_TX_ARB_WATCHDOG_EN.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [7:0]         data_tx_o,
  output logic               tx_fifo_write_o,
  input  logic               tx_fifo_full_i,
  input  logic               tx_fifo_empty_i,
  input  logic               cfg_req_i,
  output logic               cfg_busy_o,
  output logic               cfg_done_o,
  output logic               config_req_mst_o,
  input  logic               req_done_i,
  output logic               wdog_err_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, CFG_DRAIN, CFG_REQ} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] sel_q, sel_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          cfg_busy_q, cfg_busy_d;
  logic          cfg_mst_q, cfg_mst_d;
  logic          cfg_done_q, cfg_done_d;
  logic          granted, xfer;
  logic          hi_found, lo_found;
  logic [PW-1:0] hi_pick, lo_pick, pick;

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_err_q, wdog_err_d;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES > 0);
`endif

  assign granted         = (state_q == ARB_GRANT);
  assign grant_o         = granted ? (N_REQ'(1) << sel_q) : '0;
  assign req_ready_o     = grant_o & {N_REQ{~tx_fifo_full_i}};
  assign xfer            = granted && req_valid_i[sel_q] && !tx_fifo_full_i;
  assign tx_fifo_write_o = xfer;

  always_comb begin
    data_tx_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_o[k]) data_tx_o = req_data_i[8*k +: 8];
    end
  end

  // Lowest valid index above the pointer wins; otherwise wrap to the lowest valid index overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        if (k > int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_pick  = PW'(k);
        end
        lo_found = 1'b1;
        lo_pick  = PW'(k);
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    cfg_busy_d = cfg_busy_q | cfg_req_i;
    cfg_mst_d  = cfg_mst_q;
    cfg_done_d = 1'b0;
`ifdef UART_TX_ARB_WATCHDOG_EN
    wdog_cnt_d = '0;
    wdog_err_d = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (cfg_busy_q) begin
          state_d = CFG_DRAIN;
        end else if (lo_found) begin
          sel_d   = pick;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (xfer && req_last_i[sel_q]) begin
          ptr_d   = sel_q;
          state_d = ARB_IDLE;
        end
`ifdef UART_TX_ARB_WATCHDOG_EN
        else if (req_valid_i[sel_q]) begin
          wdog_cnt_d = '0;
        end else if (wdog_cnt_q == CW'(WDOG_CYCLES - 1)) begin
          ptr_d      = sel_q;
          state_d    = ARB_IDLE;
          wdog_err_d = 1'b1;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
`endif
      end
      CFG_DRAIN: begin
        if (tx_fifo_empty_i) begin
          cfg_mst_d = 1'b1;
          state_d   = CFG_REQ;
        end
      end
      CFG_REQ: begin
        if (req_done_i) begin
          cfg_mst_d  = 1'b0;
          cfg_done_d = 1'b1;
          cfg_busy_d = 1'b0;
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ARB_IDLE;
      sel_q      <= '0;
      ptr_q      <= PW'(N_REQ - 1);
      cfg_busy_q <= 1'b0;
      cfg_mst_q  <= 1'b0;
      cfg_done_q <= 1'b0;
`ifdef UART_TX_ARB_WATCHDOG_EN
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      cfg_busy_q <= cfg_busy_d;
      cfg_mst_q  <= cfg_mst_d;
      cfg_done_q <= cfg_done_d;
`ifdef UART_TX_ARB_WATCHDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
`endif
    end
  end

  assign cfg_busy_o       = cfg_busy_q;
  assign cfg_done_o       = cfg_done_q;
  assign config_req_mst_o = cfg_mst_q;
`ifdef UART_TX_ARB_WATCHDOG_EN
  assign wdog_err_o       = wdog_err_q;
`else
  assign wdog_err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4): packet atomicity, round-robin order, FIFO-full stall,
// config drain/request sequencing and asynchronous reset.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk_i = 1'b0;
  logic           rst_n_i;
  logic [N-1:0]   req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_last_i;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   grant_o;
  logic [7:0]     data_tx_o;
  logic           tx_fifo_write_o;
  logic           tx_fifo_full_i;
  logic           tx_fifo_empty_i;
  logic           cfg_req_i;
  logic           cfg_busy_o;
  logic           cfg_done_o;
  logic           config_req_mst_o;
  logic           req_done_i;
  logic           wdog_err_o;

  always #5 clk_i = ~clk_i;

  uart_tx_arbiter #(.N_REQ(N), .WDOG_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o), .data_tx_o(data_tx_o),
    .tx_fifo_write_o(tx_fifo_write_o), .tx_fifo_full_i(tx_fifo_full_i),
    .tx_fifo_empty_i(tx_fifo_empty_i), .cfg_req_i(cfg_req_i), .cfg_busy_o(cfg_busy_o),
    .cfg_done_o(cfg_done_o), .config_req_mst_o(config_req_mst_o),
    .req_done_i(req_done_i), .wdog_err_o(wdog_err_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Per-source packet streams: pk_len bytes split into packets of pk_plen bytes.
  logic [7:0] pk_dat [N][16];
  int         pk_len [N];
  int         pk_plen[N];
  int         pk_idx [N];
  bit         s_full [64];
  bit         s_empty[64];
  bit         s_cfg  [64];
  bit         s_done [64];

  logic [7:0] wr_dat[$];
  logic [3:0] wr_gnt[$];
  logic       lg_wr  [64];
  logic [3:0] lg_gnt [64];
  logic [3:0] lg_rdy [64];
  logic       lg_busy[64];
  logic       lg_mst [64];
  logic       lg_done[64];
  logic       lg_wdog[64];

  always @(negedge clk_i) begin
    if (rst_n_i && cyc < 64) begin
      lg_wr[cyc]   = tx_fifo_write_o;
      lg_gnt[cyc]  = grant_o;
      lg_rdy[cyc]  = req_ready_o;
      lg_busy[cyc] = cfg_busy_o;
      lg_mst[cyc]  = config_req_mst_o;
      lg_done[cyc] = cfg_done_o;
      lg_wdog[cyc] = wdog_err_o;
      if (tx_fifo_write_o) begin
        wr_dat.push_back(data_tx_o);
        wr_gnt.push_back(grant_o);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, grant_o, 0);
    chk({tag, "_ready"}, req_ready_o, 0);
    chk({tag, "_write"}, tx_fifo_write_o, 0);
    chk({tag, "_data"},  data_tx_o, 0);
    chk({tag, "_mst"},   config_req_mst_o, 0);
    chk({tag, "_busy"},  cfg_busy_o, 0);
    chk({tag, "_done"},  cfg_done_o, 0);
    chk({tag, "_wdog"},  wdog_err_o, 0);
  endtask

  task automatic clear_test();
    for (int k = 0; k < N; k++) begin
      pk_len[k]  = 0;
      pk_plen[k] = 1;
      pk_idx[k]  = 0;
      for (int i = 0; i < 16; i++) pk_dat[k][i] = 8'h00;
    end
    for (int c = 0; c < 64; c++) begin
      s_full[c] = 0; s_empty[c] = 0; s_cfg[c] = 0; s_done[c] = 0;
      lg_wr[c] = 0; lg_gnt[c] = 0; lg_rdy[c] = 0; lg_busy[c] = 0;
      lg_mst[c] = 0; lg_done[c] = 0; lg_wdog[c] = 0;
    end
    wr_dat.delete();
    wr_gnt.delete();
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (pk_idx[k] < pk_len[k]) begin
        req_valid_i[k]       = 1'b1;
        req_data_i[8*k +: 8] = pk_dat[k][pk_idx[k]];
        req_last_i[k]        = ((pk_idx[k] + 1) % pk_plen[k]) == 0;
      end else begin
        req_valid_i[k]       = 1'b0;
        req_data_i[8*k +: 8] = 8'h00;
        req_last_i[k]        = 1'b0;
      end
    end
    tx_fifo_full_i  = (cyc < 64) ? s_full[cyc]  : 1'b0;
    tx_fifo_empty_i = (cyc < 64) ? s_empty[cyc] : 1'b0;
    cfg_req_i       = (cyc < 64) ? s_cfg[cyc]   : 1'b0;
    req_done_i      = (cyc < 64) ? s_done[cyc]  : 1'b0;
  endtask

  task automatic run(input int n);
    logic [N-1:0] hs;
    for (int c = 0; c < n; c++) begin
      drive();
      @(negedge clk_i);
      hs = req_valid_i & req_ready_o;
      @(posedge clk_i);
      #1;
      for (int k = 0; k < N; k++) if (hs[k]) pk_idx[k]++;
      cyc++;
    end
  endtask

  // Holds reset across two edges with this test's stimulus applied, checks outputs, then releases.
  task automatic apply_reset(input string tag);
    rst_n_i = 1'b0;
    cyc = 0;
    for (int k = 0; k < N; k++) pk_idx[k] = 0;
    drive();
    repeat (2) @(posedge clk_i);
    #1;
    chk_zero(tag);
    rst_n_i = 1'b1;
  endtask

  initial begin
    logic [7:0] e_dat [8];
    logic [3:0] e_gnt [8];
    logic       e_wr;
    logic [3:0] e_g;
    logic       e_busy, e_mst, e_done;

    rst_n_i = 1'b0;
    req_valid_i = '0; req_data_i = '0; req_last_i = '0;
    tx_fifo_full_i = 1'b0; tx_fifo_empty_i = 1'b0; cfg_req_i = 1'b0; req_done_i = 1'b0;

    // Sources 0 and 2 each with a 3-byte packet, valid together.
    clear_test();
    for (int i = 0; i < 3; i++) begin
      pk_dat[0][i] = 8'hA0 + 8'(i);
      pk_dat[2][i] = 8'hC0 + 8'(i);
    end
    pk_len[0] = 3; pk_plen[0] = 3;
    pk_len[2] = 3; pk_plen[2] = 3;
    apply_reset("rst0");
    run(10);
    for (int i = 0; i < 3; i++) begin
      e_dat[i] = 8'hA0 + 8'(i); e_gnt[i] = 4'b0001;
      e_dat[i+3] = 8'hC0 + 8'(i); e_gnt[i+3] = 4'b0100;
    end
    chk("t1_nwr", wr_dat.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_dat%0d", i), wr_dat[i], e_dat[i]);
      chk($sformatf("t1_gnt%0d", i), wr_gnt[i], e_gnt[i]);
    end

    // All four sources continuously valid with 1-byte packets.
    clear_test();
    for (int k = 0; k < N; k++) begin
      pk_len[k] = 2; pk_plen[k] = 1;
      for (int i = 0; i < 2; i++) pk_dat[k][i] = 8'(16 * (k + 1) + i);
    end
    apply_reset("rst1");
    run(18);
    for (int i = 0; i < 8; i++) begin
      e_dat[i] = 8'(16 * ((i % 4) + 1) + (i / 4));
      e_gnt[i] = 4'b0001 << (i % 4);
    end
    chk("t2_nwr", wr_dat.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_dat%0d", i), wr_dat[i], e_dat[i]);
      chk($sformatf("t2_gnt%0d", i), wr_gnt[i], e_gnt[i]);
    end

    // FIFO full for cycles 3..7 in the middle of a 6-byte packet from source 1.
    clear_test();
    for (int i = 0; i < 6; i++) pk_dat[1][i] = 8'h50 + 8'(i);
    pk_len[1] = 6; pk_plen[1] = 6;
    for (int c = 3; c <= 7; c++) s_full[c] = 1;
    apply_reset("rst2");
    run(13);
    for (int c = 0; c < 12; c++) begin
      e_wr = (c >= 1 && c <= 2) || (c >= 8 && c <= 11);
      chk($sformatf("t3_wr_c%0d", c), lg_wr[c], e_wr);
      chk($sformatf("t3_rdy_c%0d", c), lg_rdy[c], {2'b00, e_wr, 1'b0});
    end
    chk("t3_nwr", wr_dat.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_dat%0d", i), wr_dat[i], 8'h50 + 8'(i));

    // Config pulse during a source-1 packet; source 3 waits; stray pulses are ignored.
    clear_test();
    for (int i = 0; i < 4; i++) pk_dat[1][i] = 8'h60 + 8'(i);
    pk_len[1] = 4; pk_plen[1] = 4;
    pk_dat[3][0] = 8'h70; pk_len[3] = 1; pk_plen[3] = 1;
    s_cfg[2] = 1; s_cfg[6] = 1;
    s_done[7] = 1; s_done[12] = 1;
    for (int c = 9; c < 64; c++) s_empty[c] = 1;
    apply_reset("rst3");
    run(16);
    for (int c = 0; c < 16; c++) begin
      e_g    = (c >= 1 && c <= 4) ? 4'b0010 : (c == 14) ? 4'b1000 : 4'b0000;
      e_wr   = (c >= 1 && c <= 4) || (c == 14);
      e_busy = (c >= 3 && c <= 12);
      e_mst  = (c >= 10 && c <= 12);
      e_done = (c == 13);
      chk($sformatf("t4_c%0d", c),
          {lg_gnt[c], lg_wr[c], lg_busy[c], lg_mst[c], lg_done[c], lg_wdog[c]},
          {e_g, e_wr, e_busy, e_mst, e_done, 1'b0});
    end
    chk("t4_nwr", wr_dat.size(), 5);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_dat%0d", i), wr_dat[i], 8'h60 + 8'(i));
    chk("t4_dat4", wr_dat[4], 8'h70);

    // Asynchronous reset while the config request is held.
    clear_test();
    pk_dat[1][0] = 8'h60; pk_dat[1][1] = 8'h61;
    pk_len[1] = 2; pk_plen[1] = 2;
    s_cfg[0] = 1;
    for (int c = 0; c < 64; c++) s_empty[c] = 1;
    apply_reset("rst4");
    run(7);
    chk("t5_mst_held", config_req_mst_o, 1);
    chk("t5_busy_held", cfg_busy_o, 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_zero("t5_arst_cfg");
    clear_test();
    for (int k = 0; k < N; k++) begin
      pk_len[k] = 1; pk_dat[k][0] = 8'h90 + 8'(k);
    end
    apply_reset("rst5");
    run(3);
    chk("t5_first_gnt", lg_gnt[1], 4'b0001);
    chk("t5_first_dat", wr_dat[0], 8'h90);

    // Asynchronous reset in the middle of a source-0 packet.
    clear_test();
    for (int i = 0; i < 5; i++) pk_dat[0][i] = 8'h80 + 8'(i);
    pk_len[0] = 5; pk_plen[0] = 5;
    pk_dat[1][0] = 8'h88; pk_len[1] = 1;
    apply_reset("rst6");
    run(3);
    chk("t5_mid_gnt", grant_o, 4'b0001);
    chk("t5_mid_nwr", wr_dat.size(), 2);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_zero("t5_arst_pkt");
    clear_test();
    for (int k = 0; k < N; k++) begin
      pk_len[k] = 1; pk_dat[k][0] = 8'hB0 + 8'(k);
    end
    apply_reset("rst7");
    run(3);
    chk("t5_after_gnt", lg_gnt[1], 4'b0001);
    chk("t5_after_dat", wr_dat[0], 8'hB0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
